// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer
// Walks the elements of two vector registers, issuing paired reads to a
// dual-port VRF RAM with a one-cycle registered read latency, and buffers
// the returned operand pairs in a small FIFO for a downstream consumer.
// Issue is throttled so that buffered plus in-flight pairs never exceed
// the FIFO depth, which lets reads be issued without looking at op_ready.

module vrf_read_sequencer #(
  parameter int DATA_W     = 32,
  parameter int NUM_ELEM   = 8,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_vs1,
  input  logic [4:0]        req_vs2,
  input  logic [3:0]        req_vl,
  output logic              ram_re,
  output logic [7:0]        ram_raddr1,
  output logic [7:0]        ram_raddr2,
  input  logic [DATA_W-1:0] ram_rdataA,
  input  logic [DATA_W-1:0] ram_rdataB,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_idx,
  output logic              op_last,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0]       MAX_VL    = 4'(NUM_ELEM);
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  // Request context and issue progress
  logic [1:0] state;
  logic [4:0] vs1_q;
  logic [4:0] vs2_q;
  logic [3:0] vl_q;
  logic [2:0] elem;

  // One read is in flight when pending is set; pend_idx is its element
  logic       pending;
  logic [2:0] pend_idx;

  // Last issued addresses, shown on the RAM ports while no read is issued
  logic [7:0] addr1_q;
  logic [7:0] addr2_q;

  // Operand-pair FIFO
  logic [DATA_W-1:0] fifo_a    [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_b    [FIFO_DEPTH];
  logic [2:0]        fifo_idx  [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Combinational helpers
  logic             accept;
  logic [3:0]       vl_sat;
  logic [3:0]       vl_m1;
  logic             last_elem;
  logic [CNT_W:0]   occ_sum;
  logic             push;
  logic             pop;
  logic             push_last;
  logic [CNT_W-1:0] count_nxt;

  // Wrap a FIFO pointer at the (possibly non power-of-two) depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake, throttling and FIFO bookkeeping decisions
  always_comb begin
    req_ready = (state == IDLE) && nrst;
    busy      = (state != IDLE);
    accept    = req_valid && req_ready;
    vl_sat    = (req_vl > MAX_VL) ? MAX_VL : req_vl;
    vl_m1     = vl_q - 4'd1;
    last_elem = (elem == vl_m1[2:0]);
    occ_sum   = {1'b0, count} + (CNT_W + 1)'(pending);
    ram_re    = (state == ISSUE) && (occ_sum <= OCC_LIMIT);
    push      = pending;
    push_last = (pend_idx == vl_m1[2:0]);
    op_valid  = (count != '0);
    pop       = op_valid && op_ready;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // RAM addresses track the element being issued and hold otherwise
  always_comb begin
    ram_raddr1 = addr1_q;
    ram_raddr2 = addr2_q;
    if (ram_re) begin
      ram_raddr1 = {vs1_q, elem};
      ram_raddr2 = {vs2_q, elem};
    end
  end

  // FIFO head drives the operand outputs
  always_comb begin
    op_a    = fifo_a[rd_ptr];
    op_b    = fifo_b[rd_ptr];
    op_idx  = fifo_idx[rd_ptr];
    op_last = fifo_last[rd_ptr];
  end

  // Sequencer state: accept, walk elements, then wait for the FIFO to drain
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      vs1_q <= '0;
      vs2_q <= '0;
      vl_q  <= '0;
      elem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vs1_q <= req_vs1;
            vs2_q <= req_vs2;
            vl_q  <= vl_sat;
            elem  <= '0;
            if (vl_sat != 4'd0) begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (ram_re) begin
            elem <= elem + 3'd1;
            if (last_elem) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!pending && (count_nxt == '0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight read tracking and held RAM addresses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending  <= 1'b0;
      pend_idx <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
    end else begin
      pending <= ram_re;
      if (ram_re) begin
        pend_idx <= elem;
        addr1_q  <= {vs1_q, elem};
        addr2_q  <= {vs2_q, elem};
      end
    end
  end

  // Operand-pair FIFO: capture returning RAM data, release on handshake
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_a[i]    <= '0;
        fifo_b[i]    <= '0;
        fifo_idx[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_a[wr_ptr]    <= ram_rdataA;
        fifo_b[wr_ptr]    <= ram_rdataB;
        fifo_idx[wr_ptr]  <= pend_idx;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: doc/vrf_read_sequencer.md
VRF_READ_SEQUENCER -- requirements
Module: vrf_read_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element width in bits.
REQ-002 SHALL have parameter NUM_ELEM, default 8, elements per vector register; RAM address = {vs[4:0], elem[2:0]}.
REQ-003 SHALL have parameter FIFO_DEPTH, default 3, operand-pair buffer entries.
REQ-004 SHALL use clock clk and reset nrst, asynchronous, active-low.
REQ-005 Ports (name direction width meaning):
 clk  in  1  clock
 nrst  in  1  asynchronous active-low reset
 req_valid  in  1  vector read request offered
 req_ready  out  1  sequencer can accept request
 req_vs1  in  5  source register A index
 req_vs2  in  5  source register B index
 req_vl  in  4  vector length, 0..8
 ram_re  out  1  read enable to VRF RAM
 ram_raddr1  out  8  RAM port A address
 ram_raddr2  out  8  RAM port B address
 ram_rdataA  in  DATA_W  RAM port A data, registered, 1-cycle latency
 ram_rdataB  in  DATA_W  RAM port B data, registered, 1-cycle latency
 op_valid  out  1  operand pair available
 op_ready  in  1  consumer accepts pair
 op_a  out  DATA_W  element of vs1
 op_b  out  DATA_W  element of vs2
 op_idx  out  3  element index of pair
 op_last  out  1  pair is final element of request
 busy  out  1  request in progress

Function
REQ-006 States SHALL be IDLE, ISSUE, DRAIN; req_ready=1 only in IDLE; busy=(state!=IDLE).
REQ-007 Request SHALL be accepted on a clock edge with req_valid&&req_ready; vs1, vs2, and min(req_vl,8) SHALL be latched.
REQ-008 Accept with vl=0 SHALL stay in IDLE, issue no reads, produce no pairs.
REQ-009 Accept with vl>=1 SHALL go IDLE->ISSUE, element counter e=0.
REQ-010 In ISSUE, ram_re SHALL be 1 iff fifo_count + pending <= FIFO_DEPTH-1, where pending=registered ram_re of the previous cycle; no dependence on op_ready.
REQ-011 When ram_re=1: ram_raddr1={vs1,e}, ram_raddr2={vs2,e}; e increments at the edge; after issuing e=vl-1, state goes ISSUE->DRAIN.
REQ-012 When ram_re=0, ram_raddr1/2 SHALL hold their last values.
REQ-013 In any cycle with pending=1, {ram_rdataA, ram_rdataB, idx, last} SHALL be pushed into the FIFO at the end of that cycle; last=1 iff idx==vl-1.
REQ-014 op_valid SHALL equal FIFO non-empty; op_a/op_b/op_idx/op_last SHALL show the head entry; pop on op_valid&&op_ready.
REQ-015 Simultaneous push and pop SHALL keep count unchanged with order preserved; FIFO SHALL never overflow.
REQ-016 DRAIN->IDLE SHALL occur at the edge where pending=0 and FIFO becomes or is empty; the next request may then be accepted.
REQ-017 With op_ready held high, pairs SHALL stream at one per cycle; first op_valid SHALL occur 3 cycles after the accept edge (re cycle +1, RAM cycle +2, FIFO visible +3).
REQ-018 Holding op_ready low SHALL stall issue after at most FIFO_DEPTH pairs are buffered/in flight; no data loss or duplication.
REQ-019 vs1==vs2 SHALL be legal and return identical a/b.

Reset
REQ-020 nrst low SHALL force IDLE, e=0, pending=0, FIFO empty, ram_re=0, ram_raddr1/2=0, op_valid=0, op_a/op_b=0, op_idx=0, op_last=0, busy=0, req_ready=0 while nrst low.
REQ-021 Reset mid-request SHALL abandon the request; no pair from it SHALL appear after reset release.

Verification
REQ-022 RAM preloaded mem[a]=a; request vs1=2, vs2=5, vl=8, op_ready=1 -> 8 consecutive pairs a=16..23, b=40..47, idx 0..7, op_last only on idx 7, first op_valid 3 cycles after accept.
REQ-023 vl=3, op_ready=0 for 10 cycles then 1 -> ram_re asserted exactly 3 times, 3 pairs idx 0,1,2 in order, op_last on idx 2.
REQ-024 vl=8, op_ready toggling 1/0 each cycle -> no lost/duplicate pairs, FIFO count never >3, ram_re never asserted with count+pending=3.
REQ-025 vl=0 -> req_ready stays 1, ram_re never asserted, no op_valid; vl=12 -> exactly 8 pairs.
REQ-026 nrst pulsed low after 4th pair of vl=8 request -> all outputs reset values, no further pairs, next request vs1=1, vs2=1, vl=2 returns a=b=8,9.
REQ-027 Back-to-back requests with req_valid held high -> second accepted only after first's op_last popped; pairs of second follow with correct addresses.
